// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with a small TX FIFO, an RX holding register
// and sticky error flags. Registers: TXDATA (write), RXDATA (read), STATUS (read).
`timescale 1ns/1ps
module uart_mmio #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter logic [31:0] BASE         = 32'd1280,
    parameter int unsigned TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    input  logic        uart_rx
);
    // Baud counter only ever needs to reach CLKS_PER_BIT-1; pointers wrap
    // naturally because TX_DEPTH is a power of two (minimum 2).
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2 - 1) : 0);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic wr_txdata, rd_rxdata, rd_status;
    assign wr_txdata = mem_en && !mem_read && (addr == BASE);
    assign rd_rxdata = mem_en &&  mem_read && (addr == BASE + 32'd4);
    assign rd_status = mem_en &&  mem_read && (addr == BASE + 32'd8);

    // Only the low byte of a TXDATA write is meaningful.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   tx_count;
    logic             fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_empty = (tx_count == '0);
    assign fifo_full  = (tx_count == FULL_CNT);
    // A write to a full FIFO is still taken when the TX side pops on the same edge.
    assign fifo_push  = wr_txdata && (!fifo_full || fifo_pop);

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   tx_count <= tx_count + (PTR_W + 1)'(1);
                2'b01:   tx_count <= tx_count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_out_n;
    logic             tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // TX next state: pop at IDLE or at the end of STOP so frames run back to back
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_mem[rd_ptr];
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_n = fifo_mem[rd_ptr];
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Line level is registered from the next state so uart_tx is glitch-free.
        case (tx_state_n)
            TX_START: tx_out_n = 1'b0;
            TX_DATA:  tx_out_n = tx_shift_n[0];
            default:  tx_out_n = 1'b1;
        endcase
    end

    // TX control registers and serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            uart_tx  <= tx_out_n;
        end
    end

    // TX shift register (data path)
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_n;
    end

    // ---------------- RX path ----------------
    logic rx_s1, rx_s2, rx_prev;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_brk, rx_brk_n;
    logic             rx_load, rx_ferr_set;
    logic             rx_bit_end;

    assign rx_bit_end = (rx_cnt == BIT_LAST);

    // RX next state: half-bit into START to qualify, then full bits to each centre.
    // rx_brk marks a bad stop bit; STOP is held until the line is seen high again.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_brk_n    = rx_brk;
        rx_load     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_brk) begin
                    if (rx_s2) begin
                        rx_brk_n   = 1'b0;
                        rx_state_n = RX_IDLE;
                    end
                end else if (rx_bit_end) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        rx_load    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_brk_n    = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // RX control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_brk   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_brk   <= rx_brk_n;
        end
    end

    // RX shift register and holding byte (data path)
    logic [7:0] rx_byte;
    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_n;
        if (rx_load) rx_byte <= rx_shift;
    end

    // ---------------- flags and read data ----------------
    logic rx_valid, overrun, ferr;
    logic tx_idle;
    assign tx_idle = fifo_empty && (tx_state == TX_IDLE);

    // Sticky flags: a set on the same edge as a clearing read wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (rx_load)        rx_valid <= 1'b1;
            else if (rd_rxdata) rx_valid <= 1'b0;
            if (rx_load && rx_valid && !rd_rxdata) overrun <= 1'b1;
            else if (rd_status)                    overrun <= 1'b0;
            if (rx_ferr_set)    ferr <= 1'b1;
            else if (rd_status) ferr <= 1'b0;
        end
    end

    // Registered read data, held until the next decoded read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_rxdata) begin
            rdata <= rx_valid ? {24'b0, rx_byte} : 32'b0;
        end else if (rd_status) begin
            rdata <= {27'b0, ferr, overrun, rx_valid, tx_idle, fifo_full};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed + randomized bench for uart_mmio with a frame-level model.
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'd1280;
    localparam int          FB   = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n, mem_en, mem_read, uart_tx, uart_rx;
    logic [31:0] addr, wdata, rdata;

    uart_mmio #(.CLKS_PER_BIT(CPB), .BASE(BASE), .TX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Serial line recorder, one sample per cycle on the falling edge
    bit   rec = 1'b0;
    logic tx_log[$];
    always @(negedge clk) if (rec) tx_log.push_back(uart_tx);

    // Frame-level reference state
    logic [7:0]  exp_tx[$];
    bit          m_valid = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0]  m_byte = '0;
    logic [31:0] last_rd = '0;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_en = 1'b1; mem_read = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        mem_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mem_en = 1'b1; mem_read = 1'b1; addr = a;
        @(negedge clk);
        mem_en = 1'b0;
        d = rdata;
    endtask

    task automatic read_status_chk(input string tag, input bit idle, input bit full);
        logic [31:0] d, e;
        e = {27'b0, m_ferr, m_ovr, m_valid, idle, full};
        bus_read(BASE + 32'd8, d);
        m_ferr = 0; m_ovr = 0; last_rd = e;
        chk(tag, d, e);
    endtask

    task automatic read_rxdata_chk(input string tag);
        logic [31:0] d, e;
        e = m_valid ? {24'b0, m_byte} : 32'b0;
        bus_read(BASE + 32'd4, d);
        m_valid = 0; last_rd = e;
        chk(tag, d, e);
    endtask

    // One serial frame on uart_rx, then idle; the model applies the frame's effect.
    task automatic rx_frame(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_byte  = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic tx_capture_start();
        tx_log.delete();
        exp_tx.delete();
        @(posedge clk);
        #1 rec = 1'b1;
        @(negedge clk);
    endtask

    // Expected line: first low two samples after capture start, frames contiguous.
    task automatic tx_wait_check(input string tag);
        int          i0, n;
        logic [63:0] obs, ev;
        logic [7:0]  eb;
        n = exp_tx.size();
        repeat (n * FB + 4 * CPB + 4) @(negedge clk);
        rec = 1'b0;
        i0 = -1;
        for (int i = 0; i < tx_log.size(); i++)
            if (tx_log[i] === 1'b0) begin i0 = i; break; end
        chk({tag, "_first_low"}, 64'(i0), 64'd2);
        if (i0 < 0) i0 = 2;
        for (int k = 0; k < n; k++) begin
            obs = '0; ev = '0; eb = exp_tx[k];
            for (int j = 0; j < FB; j++) begin
                int idx;
                idx = i0 + k * FB + j;
                obs[j] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
                if (j < CPB)          ev[j] = 1'b0;
                else if (j < 9 * CPB) ev[j] = eb[j / CPB - 1];
                else                  ev[j] = 1'b1;
            end
            chk($sformatf("%s_frame%0d", tag, k), obs, ev);
        end
        obs = '0; ev = '0;
        for (int j = 0; j < 2 * CPB; j++) begin
            int idx;
            idx = i0 + n * FB + j;
            obs[j] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
            ev[j]  = 1'b1;
        end
        chk({tag, "_idle_after"}, obs, ev);
    endtask

    initial begin
        logic [31:0] d, wd;
        logic [7:0]  b;
        int          n, zeros;

        rst_n = 1'b0; mem_en = 1'b0; mem_read = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
        #12;
        chk("reset_uart_tx", uart_tx, 1);
        chk("reset_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_status_chk("status_after_reset", 1, 0);

        // Single byte frame
        tx_capture_start();
        bus_write(BASE, 32'h0000_0055); exp_tx.push_back(8'h55);
        tx_wait_check("tx55");
        read_status_chk("status_after_tx55", 1, 0);

        // Burst: five queue up, sixth dropped, a write on the pop edge of a full FIFO accepted
        tx_capture_start();
        for (int i = 1; i <= 5; i++) begin
            bus_write(BASE, 32'(i));
            exp_tx.push_back(8'(i));
        end
        bus_write(BASE, 32'h66);
        read_status_chk("status_fifo_full", 0, 1);
        repeat (34) @(negedge clk);
        bus_write(BASE, 32'h77); exp_tx.push_back(8'h77);
        tx_wait_check("burst");
        read_status_chk("status_after_burst", 1, 0);

        // Undecoded accesses: no effect, rdata held
        bus_write(BASE + 32'd4, 32'hAB);
        bus_write(BASE + 32'd12, 32'hCD);
        bus_read(BASE + 32'd12, d);
        chk("undecoded_read_hold", d, last_rd);
        read_status_chk("status_after_undecoded", 1, 0);
        read_rxdata_chk("rxdata_empty");

        // RX single frame
        rx_frame(8'hA3, 1);
        read_status_chk("status_rx_valid", 1, 0);
        read_rxdata_chk("rxdata_a3");
        bus_read(BASE + 32'd16, d);
        chk("rxdata_hold", d, last_rd);
        read_status_chk("status_after_rxread", 1, 0);

        // Overrun
        rx_frame(8'h11, 1);
        rx_frame(8'h22, 1);
        read_status_chk("status_overrun", 1, 0);
        read_rxdata_chk("rxdata_22");
        read_status_chk("status_ovr_cleared", 1, 0);
        rx_frame(8'h33, 1);
        rx_frame(8'h44, 1);
        read_rxdata_chk("rxdata_44");
        read_status_chk("status_ovr_no_valid", 1, 0);
        read_status_chk("status_ovr_cleared2", 1, 0);

        // Framing error, then glitch rejection, then a good frame
        rx_frame(8'h5C, 0);
        read_status_chk("status_ferr", 1, 0);
        read_status_chk("status_ferr_cleared", 1, 0);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        read_status_chk("status_after_glitch", 1, 0);
        rx_frame(8'h96, 1);
        read_rxdata_chk("rxdata_after_glitch");

        // Randomized mix of RX frames, register reads and TX bursts
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: rx_frame(8'($urandom()), $urandom_range(0, 3) != 0);
                1: read_rxdata_chk($sformatf("rand_rxdata%0d", it));
                2: read_status_chk($sformatf("rand_status%0d", it), 1, 0);
                default: begin
                    n = $urandom_range(1, 5);
                    tx_capture_start();
                    for (int i = 0; i < n; i++) begin
                        b = 8'($urandom());
                        wd = $urandom();
                        wd[7:0] = b;
                        bus_write(BASE, wd);
                        exp_tx.push_back(b);
                    end
                    tx_wait_check($sformatf("rand_tx%0d", it));
                end
            endcase
        end
        read_status_chk("rand_final_status", 1, 0);
        read_rxdata_chk("rand_final_rxdata");

        // Asynchronous reset during data bit 3 of the first of three queued frames
        b = 8'($urandom()) & 8'hF7;
        bus_write(BASE, {24'h0, b});
        bus_write(BASE, 32'h5A);
        bus_write(BASE, 32'hC3);
        repeat (16) @(negedge clk);
        chk("rst_pre_bit3_low", uart_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx_high", uart_tx, 1);
        chk("rst_async_rdata", rdata, 0);
        m_valid = 0; m_ovr = 0; m_ferr = 0; last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_capture_start();
        read_status_chk("status_after_midframe_reset", 1, 0);
        repeat (3 * FB) @(negedge clk);
        rec = 1'b0;
        zeros = 0;
        foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
        chk("tx_quiet_after_reset", 64'(zeros), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
